// File: rtl/block_match_pkg.sv
// Shared FSM state type, coordinate width and cost-width sizing helper for the
// block matcher cost stage.
package block_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_PUBLISH
  } state_e;

  localparam int COORD_W = 16;

  // Smallest width that holds every cost from 0 up to width*height.
  function automatic int cost_width(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

endpackage

// File: rtl/bm_row_popcount.sv
// Combinational population count of one block row (XOR of reference and candidate).
module bm_row_popcount #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/block_match_cost_min.sv
// Hamming-cost pipeline plus running-minimum tracker, one result per search on a
// valid/ready port. Define BM_SECOND_BEST_EN to also track the second-lowest cost.
module block_match_cost_min
  import block_match_pkg::*;
#(
  parameter int BLOCK_WIDTH  = 16,
  parameter int BLOCK_HEIGHT = 16,
  parameter int COST_W       = cost_width(BLOCK_WIDTH, BLOCK_HEIGHT)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [BLOCK_WIDTH*BLOCK_HEIGHT-1:0] blk_block,
  input  logic [BLOCK_WIDTH*BLOCK_HEIGHT-1:0] srch_block,
  input  logic [COORD_W-1:0]              coords_in,
  input  logic [15:0]                     blk_index_in,
  input  logic                            blks_valid,
  input  logic                            match_done,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [COORD_W-1:0]              best_coords,
  output logic [COST_W-1:0]               best_cost,
  output logic [15:0]                     result_index,
  output logic [COST_W-1:0]               second_cost,
  output logic                            overrun
);

  localparam int ROW_W = $clog2(BLOCK_WIDTH + 1);

  state_e               state_q;
  logic                 match_done_q;
  logic                 accept, drop;
  logic [ROW_W-1:0]     s1_row_d [BLOCK_HEIGHT];
  logic [ROW_W-1:0]     s1_row_q [BLOCK_HEIGHT];
  logic [COORD_W-1:0]   s1_coords_q, s2_coords_q;
  logic                 s1_valid_q, s2_valid_q;
  logic [COST_W-1:0]    s2_cost_d, s2_cost_q;
  logic [15:0]          index_q, result_index_q;
  logic [COST_W-1:0]    min_cost_q, best_cost_q;
  logic [COORD_W-1:0]   min_coords_q, best_coords_q;
  logic                 result_valid_q, overrun_q;
`ifdef BM_SECOND_BEST_EN
  logic [COST_W-1:0]    second_q, result_second_q;
`endif

  // Beats are only legal while idle (search start) or accumulating.
  assign accept = blks_valid && (state_q == ST_IDLE || state_q == ST_ACCUM);
  assign drop   = blks_valid && !accept;

  for (genvar r = 0; r < BLOCK_HEIGHT; r++) begin : g_row
    bm_row_popcount #(.WIDTH(BLOCK_WIDTH), .CNT_W(ROW_W)) u_pop (
      .bits_i  (blk_block[r*BLOCK_WIDTH +: BLOCK_WIDTH] ^ srch_block[r*BLOCK_WIDTH +: BLOCK_WIDTH]),
      .count_o (s1_row_d[r])
    );
  end

  always_comb begin
    s2_cost_d = '0;
    for (int r = 0; r < BLOCK_HEIGHT; r++) begin
      s2_cost_d = s2_cost_d + COST_W'(s1_row_q[r]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits above qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_row_q    <= s1_row_d;
      s1_coords_q <= coords_in;
    end
    s2_cost_q   <= s2_cost_d;
    s2_coords_q <= s1_coords_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      match_done_q   <= 1'b0;
      index_q        <= '0;
      min_cost_q     <= '1;
      min_coords_q   <= '0;
      result_valid_q <= 1'b0;
      result_index_q <= '0;
      best_cost_q    <= '1;
      best_coords_q  <= '0;
      overrun_q      <= 1'b0;
`ifdef BM_SECOND_BEST_EN
      second_q        <= '1;
      result_second_q <= '1;
`endif
    end else begin
      match_done_q <= match_done;
      if (drop) overrun_q <= 1'b1;

      // The pipeline is always empty in ST_IDLE, so search start never races a compare.
      if (state_q == ST_IDLE && blks_valid) begin
        index_q      <= blk_index_in;
        min_cost_q   <= '1;
        min_coords_q <= '0;
`ifdef BM_SECOND_BEST_EN
        second_q     <= '1;
`endif
      end else if (s2_valid_q) begin
        if (s2_cost_q < min_cost_q) begin
          min_cost_q   <= s2_cost_q;
          min_coords_q <= s2_coords_q;
`ifdef BM_SECOND_BEST_EN
          second_q     <= min_cost_q;
        end else if (s2_cost_q < second_q) begin
          second_q     <= s2_cost_q;
`endif
        end
      end

      if (state_q == ST_PUBLISH) begin
        result_valid_q  <= 1'b1;
        result_index_q  <= index_q;
        best_cost_q     <= min_cost_q;
        best_coords_q   <= min_coords_q;
`ifdef BM_SECOND_BEST_EN
        result_second_q <= second_q;
`endif
        if (result_valid_q && !result_ready) overrun_q <= 1'b1;
      end else if (result_valid_q && result_ready) begin
        result_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE:    if (blks_valid) state_q <= ST_ACCUM;
        ST_ACCUM:   if (match_done && !match_done_q) state_q <= ST_DRAIN;
        ST_DRAIN:   if (!s1_valid_q && !s2_valid_q) state_q <= ST_PUBLISH;
        ST_PUBLISH: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign result_index = result_index_q;
  assign best_cost    = best_cost_q;
  assign best_coords  = best_coords_q;
  assign overrun      = overrun_q;
`ifdef BM_SECOND_BEST_EN
  assign second_cost  = result_second_q;
`else
  assign second_cost  = '1;
`endif

endmodule
